// File: rtl/strip_alloc_pkg.sv
// Shared state encoding and fit helper for the strip width allocator and its scan unit.
package strip_alloc_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RESP} state_t;

    localparam int DEFAULT_STRIP_CAP = 128;

    // Evaluated at 32 bits so base + width can never wrap for any legal WIDTH_W.
    function automatic logic fits(input int unsigned base, input int unsigned width,
                                  input int unsigned cap);
        return (base + width) <= cap;
    endfunction

endpackage

// File: rtl/strip_width_allocator_min_scan.sv
// Sequential running-minimum unit: walks candidates 0..NUM-1, one per step, keeping the
// smallest enabled value; strict < keeps the lowest index on ties.
module strip_min_scan
    import strip_alloc_pkg::*;
#(
    parameter int NUM     = 3,
    parameter int WIDTH_W = 8,
    parameter int IDX_W   = $clog2(NUM)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step,
    input  logic               cand_en,
    input  logic [WIDTH_W-1:0] cand_w,
    output logic [IDX_W-1:0]   idx,
    output logic [WIDTH_W-1:0] best_w,
    output logic [IDX_W-1:0]   best_idx,
    output logic               best_valid,
    output logic               done
);

    assign done = step && (idx == IDX_W'(NUM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            best_w     <= '0;
            best_idx   <= '0;
            best_valid <= 1'b0;
        end else if (start) begin
            idx        <= '0;
            best_valid <= 1'b0;
        end else if (step) begin
            if (cand_en && (!best_valid || cand_w < best_w)) begin
                best_w     <= cand_w;
                best_idx   <= idx;
                best_valid <= 1'b1;
            end
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/strip_width_allocator.sv
// Strip occupancy tracker: serially finds the least-occupied enabled strip, checks the fit
// against STRIP_CAP, commits the new width and reports the placement over valid/ready.
module strip_width_allocator
    import strip_alloc_pkg::*;
#(
    parameter int NUM_STRIPS = 3,
    parameter int WIDTH_W    = 8,
    parameter int STRIP_CAP  = DEFAULT_STRIP_CAP,
    parameter int IDX_W      = $clog2(NUM_STRIPS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_STRIPS-1:0]       strip_en,
    input  logic                        clear,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [WIDTH_W-1:0]          req_width,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic                        resp_ok,
    output logic [IDX_W-1:0]            resp_strip,
    output logic [WIDTH_W-1:0]          resp_base,
    output logic [NUM_STRIPS*WIDTH_W-1:0] occ_flat
);

    state_t state, state_nxt;

    logic [WIDTH_W-1:0]    occ [NUM_STRIPS];
    logic [NUM_STRIPS-1:0] en_lat;
    logic [WIDTH_W-1:0]    width_lat;

    logic [IDX_W-1:0]   scan_idx;
    logic [IDX_W-1:0]   best_idx;
    logic [WIDTH_W-1:0] best_w;
    logic               best_valid;
    logic               scan_done;
    logic               accept;
    logic               commit_ok;

    // Gated by rst_n so the request side reads not-ready while reset is held.
    assign req_ready  = rst_n && (state == IDLE) && !clear;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);
    assign commit_ok  = best_valid && fits(32'(best_w), 32'(width_lat), 32'(STRIP_CAP));

    strip_min_scan #(
        .NUM     (NUM_STRIPS),
        .WIDTH_W (WIDTH_W),
        .IDX_W   (IDX_W)
    ) u_scan (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (accept),
        .step       (state == SCAN),
        .cand_en    (en_lat[scan_idx]),
        .cand_w     (occ[scan_idx]),
        .idx        (scan_idx),
        .best_w     (best_w),
        .best_idx   (best_idx),
        .best_valid (best_valid),
        .done       (scan_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)     state_nxt = SCAN;
            SCAN:    if (scan_done)  state_nxt = COMMIT;
            COMMIT:                  state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Request fields are sampled once at accept so later input changes cannot disturb a scan.
    always_ff @(posedge clk) begin
        if (accept) begin
            en_lat    <= strip_en;
            width_lat <= req_width;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STRIPS; i++) occ[i] <= '0;
        end else if (state == IDLE && clear) begin
            for (int i = 0; i < NUM_STRIPS; i++) occ[i] <= '0;
        end else if (state == COMMIT && commit_ok) begin
            occ[best_idx] <= best_w + width_lat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_ok    <= 1'b0;
            resp_strip <= '0;
            resp_base  <= '0;
        end else if (state == COMMIT) begin
            resp_ok    <= commit_ok;
            resp_strip <= commit_ok ? best_idx : '0;
            resp_base  <= commit_ok ? best_w : '0;
        end else if (resp_valid && resp_ready) begin
            resp_ok    <= 1'b0;
            resp_strip <= '0;
            resp_base  <= '0;
        end
    end

    for (genvar g = 0; g < NUM_STRIPS; g++) begin : g_flat
        assign occ_flat[g*WIDTH_W +: WIDTH_W] = occ[g];
    end

endmodule

// File: tb/tb_strip_width_allocator.sv
// Scoreboard bench for strip_width_allocator: directed boundary cases plus random requests
// checked against an arithmetic placement model.
module tb_strip_width_allocator;

    localparam int N   = 3;
    localparam int W   = 8;
    localparam int CAP = 128;
    localparam int IW  = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   strip_en = '0;
    logic           clear = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [W-1:0]   req_width = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic           resp_ok;
    logic [IW-1:0]  resp_strip;
    logic [W-1:0]   resp_base;
    logic [N*W-1:0] occ_flat;

    strip_width_allocator #(
        .NUM_STRIPS (N),
        .WIDTH_W    (W),
        .STRIP_CAP  (CAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .strip_en   (strip_en),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_width  (req_width),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_ok    (resp_ok),
        .resp_strip (resp_strip),
        .resp_base  (resp_base),
        .occ_flat   (occ_flat)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit ok;
        int strip;
        int base;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   m_occ[N];
    int   stall_req = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] model_flat();
        logic [N*W-1:0] v = '0;
        for (int i = 0; i < N; i++) v[i*W +: W] = W'(m_occ[i]);
        return v;
    endfunction

    // Placement rule: smallest occupancy among enabled strips, first such strip by index.
    task automatic model_place(input int w, input logic [N-1:0] en, output exp_t e);
        int mn = -1;
        bit found = 0;
        e.ok = 0; e.strip = 0; e.base = 0; e.acc = 0;
        for (int i = 0; i < N; i++)
            if (en[i] && (mn < 0 || m_occ[i] < mn)) mn = m_occ[i];
        if (mn >= 0 && mn + w <= CAP) begin
            for (int i = 0; i < N; i++) begin
                if (!found && en[i] && m_occ[i] == mn) begin
                    found = 1;
                    e.strip = i;
                end
            end
            e.ok = 1;
            e.base = mn;
            m_occ[e.strip] = mn + w;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_req(input int w, input logic [N-1:0] en, input bit clear_first,
                          input bit clear_in_scan);
        int n = 0;
        exp_t e;
        if (clear_first) drain();
        @(negedge clk);
        req_valid = 1'b1;
        req_width = W'(w);
        strip_en  = en;
        if (clear_first) begin
            clear = 1'b1;
            #1;
            chk("ready_low_during_clear", req_ready, 0);
            @(negedge clk);
            clear = 1'b0;
            for (int i = 0; i < N; i++) m_occ[i] = 0;
            #1;
            chk("occ_after_clear", occ_flat, 0);
            chk("ready_after_clear", req_ready, 1);
        end
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", req_ready, 1);
            req_valid = 1'b0;
            return;
        end
        chk("occ_before_req", occ_flat, model_flat());
        model_place(w, en, e);
        @(posedge clk);
        @(negedge clk);
        e.acc = cyc;
        sb.push_back(e);
        req_valid = 1'b0;
        req_width = W'($urandom);
        strip_en  = N'($urandom);
        if (clear_in_scan) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
        end
    endtask

    // Monitor: pops the scoreboard whenever a response is consumed.
    initial begin
        exp_t        e;
        bit          seen = 0;
        logic [10:0] held = '0;
        forever begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", resp_valid, 0);
                    resp_ready = 1'b1;
                    continue;
                end
                if (!seen) begin
                    seen = 1;
                    // Visible after the 4th edge; the consumer samples it on edge NUM_STRIPS+2.
                    chk("resp_latency", cyc - sb[0].acc, N + 1);
                end else begin
                    chk("resp_stable", {resp_ok, resp_strip, resp_base}, held);
                end
                chk("req_ready_in_resp", req_ready, 0);
                held = {resp_ok, resp_strip, resp_base};
                if (stall_req > 0) begin
                    resp_ready = 1'b0;
                    stall_req--;
                end else begin
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
                if (resp_ready) begin
                    e = sb.pop_front();
                    chk("resp_ok", resp_ok, e.ok);
                    chk("resp_strip", resp_strip, e.strip);
                    chk("resp_base", resp_base, e.base);
                    seen = 0;
                end
            end else begin
                chk("idle_resp_fields", {resp_ok, resp_strip, resp_base}, 0);
                resp_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, failures=%0d", failures);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) m_occ[i] = 0;
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_occ", occ_flat, 0);
        chk("rst_resp_fields", {resp_ok, resp_strip, resp_base}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_req_ready", req_ready, 1);

        // First placement on an empty array.
        do_req(40, 3'b111, 0, 0);
        drain();
        chk("occ_first", occ_flat, {8'd0, 8'd0, 8'd40});

        // Ties resolve to the lowest index.
        do_req(40, 3'b111, 0, 0);
        do_req(40, 3'b111, 0, 0);
        do_req(10, 3'b111, 0, 0);
        drain();
        chk("occ_tie", occ_flat, {8'd40, 8'd40, 8'd50});

        // Build {50,30,30} then a small request lands on strip 1 at base 30.
        do_req(50, 3'b001, 1, 0);
        do_req(30, 3'b110, 0, 0);
        do_req(30, 3'b110, 0, 0);
        do_req(5, 3'b111, 0, 0);
        drain();
        chk("occ_min_sel", occ_flat, {8'd30, 8'd35, 8'd50});

        // Fit boundary: exact fit accepted, overflow by one rejected (with held backpressure).
        do_req(100, 3'b001, 1, 0);
        do_req(100, 3'b010, 0, 0);
        do_req(100, 3'b100, 0, 0);
        do_req(28, 3'b111, 0, 0);
        drain();
        stall_req = 10;
        do_req(29, 3'b111, 0, 0);
        drain();
        chk("occ_fit_boundary", occ_flat, {8'd100, 8'd100, 8'd128});

        // Enable masking, clear during SCAN ignored, empty mask rejected, zero width.
        do_req(90, 3'b100, 1, 0);
        do_req(20, 3'b100, 0, 1);
        do_req(5, 3'b000, 0, 0);
        do_req(0, 3'b111, 0, 0);
        drain();
        chk("occ_mask", occ_flat, {8'd110, 8'd0, 8'd0});

        // Asynchronous reset in the middle of a scan drops the request.
        @(negedge clk);
        req_valid = 1'b1;
        req_width = 8'd10;
        strip_en  = 3'b111;
        #1;
        chk("ready_before_abort", req_ready, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        req_valid = 1'b0;
        chk("abort_resp_valid", resp_valid, 0);
        chk("abort_occ", occ_flat, 0);
        chk("abort_resp_fields", {resp_ok, resp_strip, resp_base}, 0);
        chk("abort_req_ready", req_ready, 0);
        for (int i = 0; i < N; i++) m_occ[i] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_abort_ready", req_ready, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("no_stale_resp", resp_valid, 0);
        end

        // Random traffic.
        for (int k = 0; k < 200; k++) begin
            do_req($urandom_range(0, 50), N'($urandom_range(0, 7)),
                   ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
        end
        drain();
        chk("final_occ", occ_flat, model_flat());
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/strip_width_allocator.md
Name: strip_width_allocator

Overview:
- Sequential, parametrised successor to the 3-strip combinational min-occupied-width selector used in multi-program placement.
- Holds the occupied width of each of NUM_STRIPS strips.
- Accepts program-placement requests over a valid/ready handshake and scans strips to find the least-occupied enabled one (lowest index wins ties).
- Checks fit against STRIP_CAP, commits the new width, and returns the chosen strip number over a valid/ready response channel. Sits between the program-request front end and the placement-coordinate generator.

Parameters:
- NUM_STRIPS, 3, number of strips tracked (2..16)
- WIDTH_W, 8, bit width of occupied widths and request widths
- STRIP_CAP, 128, maximum occupied width of one strip; must be < 2**WIDTH_W
- IDX_W, $clog2(NUM_STRIPS), width of the strip index

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- strip_en  input  NUM_STRIPS  per-strip enable mask; 0 = strip excluded from search
- clear  input  1  zero all occupancies (honoured only in IDLE)
- req_valid  input  1  placement request present
- req_ready  output  1  allocator can accept a request
- req_width  input  WIDTH_W  width of the program to place
- resp_valid  output  1  result available
- resp_ready  input  1  downstream consumes result
- resp_ok  output  1  1 = placed, 0 = rejected (no fit / no enabled strip)
- resp_strip  output  IDX_W  chosen strip index, 0-based; 0 when resp_ok=0
- resp_base  output  WIDTH_W  occupied width of chosen strip before commit (x-offset); 0 when rejected
- occ_flat  output  NUM_STRIPS*WIDTH_W  current occupancies, strip i at bits [i*WIDTH_W +: WIDTH_W]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all occupancies 0.
  - req_ready=0 during reset, then 1 in IDLE.
  - resp_valid=0, resp_ok=0, resp_strip=0, resp_base=0.
- Clocking: one clock; reset is asynchronous and active-low.
- FSM states:
  - IDLE:
    - req_ready = !clear.
    - If clear=1: all occupancies <- 0, no request accepted that cycle.
    - Else, on req_valid&&req_ready: latch req_width and strip_en, idx<=0, best_valid<=0, go to SCAN.
  - SCAN (exactly NUM_STRIPS cycles, idx 0..NUM_STRIPS-1): for strip idx with latched enable=1:
    - If !best_valid or occ[idx] < best_w (strict <), then best_w<=occ[idx], best_idx<=idx, best_valid<=1.
    - On idx==NUM_STRIPS-1, go to COMMIT.
  - COMMIT (1 cycle):
    - ok = best_valid && (best_w + req_width <= STRIP_CAP). The sum is computed in WIDTH_W+1 bits; no wrap.
    - If ok: occ[best_idx] <= best_w + req_width.
    - Register resp_ok, resp_strip, resp_base. Go to RESP.
  - RESP:
    - resp_valid=1; outputs held stable until resp_ready=1.
    - On resp_ready, go to IDLE: resp_valid->0 on the next edge and resp_* fields return to 0.
- Latency: accept edge at cycle 0; resp_valid high at cycle NUM_STRIPS+2. Throughput is one request per NUM_STRIPS+3 cycles with resp_ready held high.
- req_ready=0 in SCAN, COMMIT and RESP; no back-to-back overlap.
- Tie rule: equal minima resolve to the lowest index. Strict-< scan guarantees this.
- Boundaries:
  - req_width=0: placed on the min strip, occupancy unchanged, resp_ok=1.
  - Exact fit (best_w+req_width==STRIP_CAP): accepted.
  - Overflow by 1: rejected, no state change.
  - strip_en all zero: resp_ok=0, resp_strip=0.
  - strip_en changes mid-request: no effect (latched at accept).
  - clear outside IDLE: ignored.
  - clear and req_valid both in IDLE: clear wins, request stays pending.
  - rst_n low mid-operation: immediate return to reset state; in-flight request lost, no response issued.
- occ_flat always reflects registered occupancy; updates on the COMMIT edge.

Decomposition:
- Shared package strip_alloc_pkg:
  - FSM state enum (IDLE, SCAN, COMMIT, RESP)
  - default STRIP_CAP
  - function fits(base, width, cap)
- One sub-module, strip_min_scan: sequential running-minimum unit holding idx, best_w, best_idx, best_valid. It has start/step/done and strict-< compare, and is reusable by the coordinate generator.
- The top holds the occupancy array, FSM and handshakes.

Test Plan:
- Reset, then occ=0 on all strips, strip_en=3'b111, req_width=40 -> resp_ok=1, resp_strip=0, resp_base=0, occ={0,0,40}. resp_valid at cycle 5 after accept.
- Tie and min selection: occ set by prior requests to {s0=40, s1=40, s2=40}, then req 10 -> strip 0. With occ {50,30,30}, req 5 -> strip 1, resp_base=30.
- Fit boundary, occ all 100:
  - req 28 -> ok, strip 0 becomes 128.
  - req 29 -> reject: resp_ok=0, occ unchanged.
- Enable mask 3'b100 with occ {0,0,90}, req 20 -> strip 2, base 90. strip_en=0 -> resp_ok=0.
- Backpressure and clear:
  - Hold resp_ready=0 for 10 cycles -> resp fields stable, req_ready=0.
  - Assert clear in SCAN -> ignored. Assert clear in IDLE with req_valid -> occ all 0, request accepted on the following cycle.
- Reset mid-SCAN (rst_n low asynchronously between edges) -> resp_valid, occ and outputs immediately 0. After release, req_ready=1 and no stale response appears.
